dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-low reset, with ports named as listed below.
REQ-002 Ports (name, direction, width, meaning):
- clk_i in 1: clock.
- rst_ni in 1: asynchronous active-low reset.
- ld_req_i in 1: load request; level, held until ld_ack_o.
- ld_addr_i in 64: load physical address.
- ld_size_i in 2: load size (log2 bytes).
- ld_ack_o out 1: load done.
- ld_err_o out 1: load access error.
- ld_rdata_o out 64: load data.
- st_req_i in 1: store/AMO request; level, held until st_ack_o.
- st_addr_i in 64: store physical address.
- st_size_i in 2: store size.
- st_wdata_i in 64: store data.
- st_ack_o out 1: store done.
- st_err_o out 1: store access error.
- st_rdata_o out 64: AMO return data.
- mem_req_o out 1: shared port request.
- mem_we_o out 1: 1 = store.
- mem_addr_o out 64: address to the shared port.
- mem_size_o out 2: size to the shared port.
- mem_wdata_o out 64: write data to the shared port.
- mem_ack_i in 1: transaction done.
- mem_err_i in 1: transaction error.
- mem_rdata_i in 64: read data.
- perf_ld_cnt_o out 32: load grant count.
- perf_st_cnt_o out 32: store grant count.
- perf_stall_cnt_o out 32: conflict-cycle count.

Function
REQ-003 FSM states SHALL be IDLE, BUSY_LD and BUSY_ST; mem_req_o = (state != IDLE).
REQ-004 IDLE: ld_req_i=1 -> BUSY_LD; else st_req_i=1 -> BUSY_ST; else stay; load has priority on a tie.
REQ-005 On entry to a BUSY state, the granted requester's addr, size and wdata SHALL be registered; mem_addr_o, mem_size_o, mem_wdata_o and mem_we_o SHALL come only from these registers and stay stable until ack.
REQ-006 Latency: a request first seen in IDLE at cycle N SHALL produce mem_req_o=1 at cycle N+1.
REQ-007 mem_ack_i in BUSY_LD SHALL pass combinationally to ld_ack_o, with ld_err_o=mem_err_i and ld_rdata_o=mem_rdata_i; BUSY_ST SHALL do the same on the st_* outputs.
REQ-008 Ack outputs SHALL be 0 in IDLE and for the non-granted side; rdata outputs are don't-care when ack=0.
REQ-009 Handoff on ack: BUSY_LD with st_req_i=1 -> BUSY_ST (registers loaded from st_*); BUSY_ST with ld_req_i=1 -> BUSY_LD; otherwise -> IDLE.
REQ-010 The just-acked requester's req SHALL be ignored in its ack cycle, so the two sides alternate under continuous contention.
REQ-011 mem_ack_i while IDLE SHALL be ignored, with no ack to either side.
REQ-012 Request inputs changing while not granted SHALL have no effect until arbitration.

Reset
REQ-013 Reset SHALL force state=IDLE, all mem_* outputs to 0, latched registers to 0 and perf counters to 0.
REQ-014 Reset asserted mid-transaction SHALL abandon the transaction; no ack is produced for it after reset release.

Configuration
REQ-015 Macro DMEM_ARB_PERF_EN defined: perf_ld_cnt_o / perf_st_cnt_o SHALL increment on each entry into BUSY_LD / BUSY_ST.
REQ-016 Under DMEM_ARB_PERF_EN, perf_stall_cnt_o SHALL increment each cycle that a requester with req=1 is not granted; all three counters saturate at 0xFFFF_FFFF.
REQ-017 Macro DMEM_ARB_PERF_EN not defined: the perf ports SHALL still exist, tied to 0, with no counter flops.

Verification
REQ-018 Load only: ld_req_i at cycle 0, addr 0x1000, size 3; mem_ack_i at cycle 3 -> mem_req_o=1, mem_we_o=0, mem_addr_o=0x1000 during cycles 1-3; ld_ack_o=1 at cycle 3; IDLE at cycle 4.
REQ-019 Tie: ld_req_i and st_req_i both at cycle 0 -> BUSY_LD first; on load ack -> BUSY_ST next cycle with mem_we_o=1, mem_wdata_o=st_wdata_i; perf_stall_cnt_o counts the store wait cycles (macro on).
REQ-020 Continuous contention over 4 transactions -> grants L,S,L,S; perf_ld_cnt_o=2 and perf_st_cnt_o=2.
REQ-021 Store error: mem_err_i=1 with ack in BUSY_ST -> st_ack_o=1, st_err_o=1, ld_ack_o=0.
REQ-022 Reset and stray ack: rst_ni=0 during BUSY_ST -> mem_req_o=0 immediately; a stray mem_ack_i after release -> no ack on either side.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Arbitrates one shared data-memory port between a load and a store/AMO requester.
// Optional performance counters are enabled by defining DMEM_ARB_PERF_EN.
module dmem_arbiter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ld_req_i,
  input  logic [63:0] ld_addr_i,
  input  logic [1:0]  ld_size_i,
  output logic        ld_ack_o,
  output logic        ld_err_o,
  output logic [63:0] ld_rdata_o,
  input  logic        st_req_i,
  input  logic [63:0] st_addr_i,
  input  logic [1:0]  st_size_i,
  input  logic [63:0] st_wdata_i,
  output logic        st_ack_o,
  output logic        st_err_o,
  output logic [63:0] st_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [1:0]  mem_size_o,
  output logic [63:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic        mem_err_i,
  input  logic [63:0] mem_rdata_i,
  output logic [31:0] perf_ld_cnt_o,
  output logic [31:0] perf_st_cnt_o,
  output logic [31:0] perf_stall_cnt_o
);

  typedef enum logic [1:0] {IDLE, BUSY_LD, BUSY_ST} state_t;

  state_t      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        grant_ld, grant_st;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    we_d     = we_q;
    grant_ld = 1'b0;
    grant_st = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ld_req_i)      grant_ld = 1'b1;
        else if (st_req_i) grant_st = 1'b1;
      end
      // On ack the other side wins if waiting; the acked side's req is ignored this cycle.
      BUSY_LD: begin
        if (mem_ack_i) begin
          if (st_req_i) grant_st = 1'b1;
          else          state_d  = IDLE;
        end
      end
      BUSY_ST: begin
        if (mem_ack_i) begin
          if (ld_req_i) grant_ld = 1'b1;
          else          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_ld) begin
      state_d = BUSY_LD;
      addr_d  = ld_addr_i;
      size_d  = ld_size_i;
      wdata_d = '0;
      we_d    = 1'b0;
    end else if (grant_st) begin
      state_d = BUSY_ST;
      addr_d  = st_addr_i;
      size_d  = st_size_i;
      wdata_d = st_wdata_i;
      we_d    = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      we_q    <= we_d;
    end
  end

  assign mem_req_o   = (state_q != IDLE);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_size_o  = size_q;
  assign mem_wdata_o = wdata_q;

  assign ld_ack_o   = (state_q == BUSY_LD) && mem_ack_i;
  assign ld_err_o   = ld_ack_o && mem_err_i;
  assign ld_rdata_o = mem_rdata_i;
  assign st_ack_o   = (state_q == BUSY_ST) && mem_ack_i;
  assign st_err_o   = st_ack_o && mem_err_i;
  assign st_rdata_o = mem_rdata_i;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] ld_cnt_q, st_cnt_q, stall_cnt_q;
  logic        stall;

  // A requester stalls when it is neither being served nor being granted this cycle.
  assign stall = (ld_req_i && (state_q != BUSY_LD) && !grant_ld) ||
                 (st_req_i && (state_q != BUSY_ST) && !grant_st);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ld_cnt_q    <= '0;
      st_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (grant_ld && (ld_cnt_q != '1))  ld_cnt_q    <= ld_cnt_q + 32'd1;
      if (grant_st && (st_cnt_q != '1))  st_cnt_q    <= st_cnt_q + 32'd1;
      if (stall && (stall_cnt_q != '1))  stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_ld_cnt_o    = ld_cnt_q;
  assign perf_st_cnt_o    = st_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`else
  assign perf_ld_cnt_o    = '0;
  assign perf_st_cnt_o    = '0;
  assign perf_stall_cnt_o = '0;
`endif

endmodule
